// File: rtl/gpr_pkg.sv
// ============================================================================
// Module   : gpr_pkg
// Brief    : Shared GPR write types, register indices and the partial-write
//            merge helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpr_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    WORD  = 2'b01,
    DWORD = 2'b10,
    RSVD  = 2'b11
  } gpr_size_t;

  localparam logic [2:0] GPR_EAX = 3'd0;
  localparam logic [2:0] GPR_ECX = 3'd1;
  localparam logic [2:0] GPR_EDX = 3'd2;
  localparam logic [2:0] GPR_EBX = 3'd3;
  localparam logic [2:0] GPR_ESP = 3'd4;
  localparam logic [2:0] GPR_EBP = 3'd5;
  localparam logic [2:0] GPR_ESI = 3'd6;
  localparam logic [2:0] GPR_EDI = 3'd7;

  // Byte accesses alias AH..BH onto EAX..EBX through index bit 2.
  function automatic logic [2:0] gpr_target(input gpr_size_t size, input logic [2:0] index);
    gpr_target = (size == BYTE) ? {1'b0, index[1:0]} : index;
  endfunction

  function automatic logic [31:0] gpr_merge(
    input logic [31:0] base,
    input logic [31:0] data,
    input gpr_size_t   size,
    input logic [2:0]  index
  );
    logic [31:0] merged;
    merged = base;
    case (size)
      BYTE: begin
        if (index[2]) merged[15:8] = data[7:0];
        else          merged[7:0]  = data[7:0];
      end
      WORD:    merged[15:0] = data[15:0];
      default: merged       = data;
    endcase
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpr_write_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin one-hot arbiter; owns the most-recently-granted pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] request,
  input  logic             enable,
  input  logic             advance,
  output logic [WIDTH-1:0] grant
);

  localparam int LW = $clog2(WIDTH);
  localparam logic [LW-1:0] C_LAST_INIT = LW'(WIDTH - 1);

  logic [LW-1:0] r_last;
  logic [LW-1:0] w_grant_idx;
  logic [LW-1:0] w_cand;
  logic          w_found;

  // Search starts one past the last winner and wraps, so the last winner
  // is considered only after everyone else.
  always_comb begin
    grant       = '0;
    w_grant_idx = r_last;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      w_cand = LW'((int'(r_last) + k) % WIDTH);
      if (enable && !w_found && request[w_cand]) begin
        grant[w_cand] = 1'b1;
        w_grant_idx   = w_cand;
        w_found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last <= C_LAST_INIT;
    end else if (advance) begin
      r_last <= w_grant_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpr_write_arbiter.sv
// ============================================================================
// Module   : gpr_write_arbiter
// Brief    : Shares the GPR file write port among sized writeback requesters,
//            merging partial writes with bypass of the in-flight write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpr_write_arbiter
  import gpr_pkg::*;
#(
  parameter int REQUESTERS = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    hold,
  input  logic [REQUESTERS-1:0]   req_valid,
  output logic [REQUESTERS-1:0]   req_ready,
  input  logic [2*REQUESTERS-1:0] req_size,
  input  logic [3*REQUESTERS-1:0] req_index,
  input  logic [32*REQUESTERS-1:0] req_data,
  input  logic [255:0]            gpr_read_32,
  output logic                    write_enable,
  output logic [2:0]              write_index,
  output logic [31:0]             write_data
);

  logic [REQUESTERS-1:0] w_grant;
  logic                  w_enable;
  logic                  w_accept;
  logic [1:0]            w_sel_size;
  logic [2:0]            w_sel_index;
  logic [31:0]           w_sel_data;
  gpr_size_t             w_size;
  logic [2:0]            w_target;
  logic [31:0]           w_base;
  logic [31:0]           w_merged;

  // Ready is also suppressed while reset is asserted.
  assign w_enable = ~hold & reset;

  rr_arbiter #(
    .WIDTH (REQUESTERS)
  ) u_rr_arbiter (
    .clock   (clock),
    .reset   (reset),
    .request (req_valid),
    .enable  (w_enable),
    .advance (w_accept),
    .grant   (w_grant)
  );

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;

  always_comb begin
    w_sel_size  = '0;
    w_sel_index = '0;
    w_sel_data  = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (w_grant[i]) begin
        w_sel_size  = req_size[2*i +: 2];
        w_sel_index = req_index[3*i +: 3];
        w_sel_data  = req_data[32*i +: 32];
      end
    end
  end

  assign w_size   = gpr_size_t'(w_sel_size);
  assign w_target = gpr_target(w_size, w_sel_index);

  // The register file only sees the in-flight write one cycle later.
  assign w_base = (write_enable && (write_index == w_target))
                ? write_data
                : gpr_read_32[{w_target, 5'd0} +: 32];

  assign w_merged = gpr_merge(w_base, w_sel_data, w_size, w_sel_index);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b0;
      write_index  <= GPR_EAX;
      write_data   <= '0;
    end else begin
      write_enable <= w_accept;
      if (w_accept) begin
        write_index <= w_target;
        write_data  <= w_merged;
      end
    end
  end

endmodule

`default_nettype wire
